lfsr_checker: RTL and testbench
===============================

// Module: lfsr_checker
// PURPOSE
//  Receive-side companion to the Galois LFSR pattern generator.
//  Consumes the generator's WIDTH-bit state word, one per valid cycle, and locks onto the sequence.
//  Once locked, it free-runs its own predictor and flags and counts mismatching words.
//  Sits at the far end of a link/loopback under test; reports lock status and error statistics.
// PARAMETERS
//  WIDTH      4    LFSR width in bits; must match the generator
//  TAPS       'h6  Galois tap mask; bit i set => stage i is XORed with the output bit; must match the generator
//  LOCK_CNT   4    consecutive correct predictions required to declare lock (>=1)
//  MISS_LIMIT 3    consecutive mismatches while locked that drop lock (>=1)
//  CNT_W      16   width of the error counters
// PORTS
//  clk          in   1        clock, rising edge
//  reset_n      in   1        asynchronous reset, active-low
//  rx_valid     in   1        rx_data is valid this cycle
//  rx_data      in   WIDTH    received generator state word
//  clear        in   1        synchronous clear of the error counters
//  locked       out  1        checker locked to the sequence
//  err          out  1        one-cycle pulse: previous valid word mismatched while locked
//  err_count    out  CNT_W    saturating count of mismatched words
//  bit_err_count out CNT_W    saturating count of mismatched bits (LFSR_CHK_BITERR_EN only)
// BEHAVIOUR
//  Reset (async assert, sync release): state=SEARCH, predictor=0, locked=0, err=0, counters=0.
//  next(s): n[WIDTH-1]=s[0]; for i<WIDTH-1: n[i] = s[i+1] ^ (TAPS[i] & s[0]). Identical to the generator.
//  Cycles with rx_valid=0 are ignored entirely: no state, predictor or counter change; err=0.
//  FSM (advances on valid cycles only):
//   SEARCH: rx_data != 0 -> predictor <= next(rx_data), match cnt <= 0, go VERIFY.
//           All-zero words are ignored (illegal LFSR state).
//   VERIFY: rx_data == predictor -> predictor <= next(predictor), cnt++.
//           When cnt reaches LOCK_CNT -> go LOCKED.
//           Mismatch -> reseed as in SEARCH (predictor <= next(rx_data), cnt <= 0) if rx_data != 0, else go SEARCH.
//   LOCKED: predictor <= next(predictor) always (flywheel; never reseeds from data).
//           Mismatch -> err=1 next cycle, err_count++ and miss++.
//           Match -> miss <= 0.
//           When miss reaches MISS_LIMIT -> go SEARCH, locked=0.
//  locked is registered: it rises the cycle after the LOCK_CNT-th match and falls the cycle after the MISS_LIMIT-th miss.
//  err: registered, 1-cycle latency from the compared word; asserted only in LOCKED (never in SEARCH/VERIFY).
//  Counters saturate at 2^CNT_W-1 and never wrap.
//  clear has priority over an increment in the same cycle: the result is 0, not 1.
//  clear does not affect FSM, locked or err.
//  Counters are retained across lock loss; only reset or clear zeroes them.
//  reset_n mid-operation: immediate return to reset values, regardless of state.
// CONFIGURATION
//  LFSR_CHK_BITERR_EN defined:
//   - bit_err_count port present.
//   - Each LOCKED mismatch adds popcount(rx_data ^ predictor) with saturation; same clear rule as err_count.
//  LFSR_CHK_BITERR_EN undefined: bit_err_count port and popcount logic absent; all other behaviour identical.
// TESTING (WIDTH=4, TAPS='h6, LOCK_CNT=4, MISS_LIMIT=3)
//  1. Lock: valid words 8,4,2,1,E,7 back-to-back from reset -> locked rises the cycle after the 5th word (E); err stays 0.
//  2. Single error: locked; inject 5 in place of the expected word -> err pulses once, err_count=1, lock held.
//     Following correct words match (flywheel); with BITERR_EN, bit_err_count = popcount of the difference.
//  3. Loss: locked; 3 consecutive wrong words -> locked falls the cycle after the 3rd, err_count=3.
//     Then feed a correct stream -> relock after 1 seed + 4 matches.
//  4. Gaps and zeros: interleave rx_valid=0 cycles and all-zero words in SEARCH -> no state change; lock timing counts valid words only.
//  5. Counters: preload near saturation (CNT_W=4): 16 errors -> err_count holds 15.
//     clear asserted together with an error -> err_count=0.
//  6. Async reset: assert reset_n=0 mid-LOCKED between clock edges -> locked, err and counters drop to 0 immediately.

Source files
------------

// File: rtl/lfsr_checker.sv
// Receive-side Galois LFSR sequence checker: seeds from data, verifies, locks, then flywheels and counts errors.
// Optional bit-error counter enabled by defining LFSR_CHK_BITERR_EN.
module lfsr_checker #(
  parameter int              WIDTH      = 4,
  parameter logic [WIDTH-1:0] TAPS      = 'h6,
  parameter int              LOCK_CNT   = 4,
  parameter int              MISS_LIMIT = 3,
  parameter int              CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rx_valid,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             clear,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count
`ifdef LFSR_CHK_BITERR_EN
  ,
  output logic [CNT_W-1:0] bit_err_count
`endif
);

  localparam int MC_W  = $clog2(LOCK_CNT + 1);
  localparam int MS_W  = $clog2(MISS_LIMIT + 1);
  localparam int PC_W  = $clog2(WIDTH + 1);
  localparam int SUM_W = CNT_W + PC_W;
  localparam logic [MC_W-1:0]  LOCK_LAST = MC_W'(LOCK_CNT - 1);
  localparam logic [MS_W-1:0]  MISS_LAST = MS_W'(MISS_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t            state;
  logic [WIDTH-1:0]  predictor;
  logic [MC_W-1:0]   match_cnt;
  logic [MS_W-1:0]   miss_cnt;
  logic              mismatch;
  logic              lock_err;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] n;
    n[WIDTH-1] = s[0];
    for (int i = 0; i < WIDTH - 1; i++) begin
      n[i] = s[i+1] ^ (TAPS[i] & s[0]);
    end
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] acc,
                                               input logic [PC_W-1:0]  inc);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(acc) + SUM_W'(inc);
    if (sum > SUM_W'(CNT_MAX)) return CNT_MAX;
    return sum[CNT_W-1:0];
  endfunction

  assign mismatch = (rx_data != predictor);
  assign lock_err = rx_valid && (state == LOCKED) && mismatch;

  // Sequence tracking: seed, verify LOCK_CNT predictions, then flywheel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SEARCH;
      predictor <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      if (rx_valid) begin
        case (state)
          SEARCH: begin
            if (rx_data != '0) begin
              predictor <= lfsr_next(rx_data);
              match_cnt <= '0;
              state     <= VERIFY;
            end
          end
          VERIFY: begin
            if (!mismatch) begin
              predictor <= lfsr_next(predictor);
              if (match_cnt == LOCK_LAST) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                miss_cnt <= '0;
              end else begin
                match_cnt <= match_cnt + MC_W'(1);
              end
            end else if (rx_data != '0) begin
              predictor <= lfsr_next(rx_data);
              match_cnt <= '0;
            end else begin
              state <= SEARCH;
            end
          end
          LOCKED: begin
            // Flywheel: data never reseeds the predictor once locked.
            predictor <= lfsr_next(predictor);
            if (mismatch) begin
              err <= 1'b1;
              if (miss_cnt == MISS_LAST) begin
                state    <= SEARCH;
                locked   <= 1'b0;
                miss_cnt <= '0;
              end else begin
                miss_cnt <= miss_cnt + MS_W'(1);
              end
            end else begin
              miss_cnt <= '0;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  // Error statistics: clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= '0;
    end else if (clear) begin
      err_count <= '0;
    end else if (lock_err) begin
      err_count <= sat_add(err_count, PC_W'(1));
    end
  end

`ifdef LFSR_CHK_BITERR_EN
  function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] d);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + PC_W'(d[i]);
    end
    return c;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_err_count <= '0;
    end else if (clear) begin
      bit_err_count <= '0;
    end else if (lock_err) begin
      bit_err_count <= sat_add(bit_err_count, popcount(rx_data ^ predictor));
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomized bench for lfsr_checker with a word-level reference model of the lock/flywheel behaviour.
// Uses CNT_W=4 so counter saturation is reachable.
module tb_lfsr_checker;

  localparam int W     = 4;
  localparam int TAPS  = 'h6;
  localparam int LOCKN = 4;
  localparam int MISSN = 3;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int WMASK = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          rx_valid = 1'b0;
  logic [W-1:0]  rx_data = '0;
  logic          clear = 1'b0;
  logic          locked;
  logic          err;
  logic [CW-1:0] err_count;
`ifdef LFSR_CHK_BITERR_EN
  logic [CW-1:0] bit_err_count;
`endif

  lfsr_checker #(
    .WIDTH(W), .TAPS(W'(TAPS)), .LOCK_CNT(LOCKN), .MISS_LIMIT(MISSN), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .clear(clear), .locked(locked), .err(err), .err_count(err_count)
`ifdef LFSR_CHK_BITERR_EN
    , .bit_err_count(bit_err_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: word-level view of the sequence tracker.
  int  g;                // generator state for stimulus
  bit  m_locked, m_seeded, m_err;
  int  m_pred, m_run, m_miss, m_ec, m_bc;

  function automatic int nxt(input int s);
    int fb;
    fb = (s & 1) ? ((1 << (W - 1)) | (TAPS & ((1 << (W - 1)) - 1))) : 0;
    return ((s >> 1) ^ fb) & WMASK;
  endfunction

  function automatic int pop(input int x);
    int c = 0;
    for (int i = 0; i < W; i++) c += (x >> i) & 1;
    return c;
  endfunction

  function automatic int sat(input int a);
    return (a > CMAX) ? CMAX : a;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_seeded = 0; m_err = 0;
    m_pred = 0; m_run = 0; m_miss = 0; m_ec = 0; m_bc = 0;
  endtask

  task automatic model_step(input bit v, input int d, input bit c);
    bit inc = 0;
    int bits = 0;
    m_err = 0;
    if (v) begin
      if (m_locked) begin
        if (d != m_pred) begin
          m_err = 1; inc = 1; bits = pop(d ^ m_pred);
          m_miss++;
          if (m_miss == MISSN) begin
            m_locked = 0; m_seeded = 0; m_miss = 0;
          end
        end else begin
          m_miss = 0;
        end
        m_pred = nxt(m_pred);
      end else if (m_seeded) begin
        if (d == m_pred) begin
          m_pred = nxt(m_pred);
          m_run++;
          if (m_run == LOCKN) begin
            m_locked = 1; m_seeded = 0; m_miss = 0;
          end
        end else if (d != 0) begin
          m_pred = nxt(d); m_run = 0;
        end else begin
          m_seeded = 0;
        end
      end else if (d != 0) begin
        m_pred = nxt(d); m_run = 0; m_seeded = 1;
      end
    end
    if (c) begin
      m_ec = 0; m_bc = 0;
    end else if (inc) begin
      m_ec = sat(m_ec + 1);
      m_bc = sat(m_bc + bits);
    end
  endtask

  task automatic cycle(input bit v, input int d, input bit c);
    @(negedge clk);
    rx_valid = v;
    rx_data  = W'(d);
    clear    = c;
    model_step(v, d, c);
    @(posedge clk);
    #1;
    check("locked", int'(locked), int'(m_locked));
    check("err", int'(err), int'(m_err));
    check("err_count", int'(err_count), m_ec);
`ifdef LFSR_CHK_BITERR_EN
    check("bit_err_count", int'(bit_err_count), m_bc);
`endif
  endtask

  task automatic good(input bit c = 0);
    cycle(1, g, c);
    g = nxt(g);
  endtask

  task automatic bad(input bit c = 0);
    cycle(1, g ^ int'($urandom_range(1, WMASK)), c);
    g = nxt(g);
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_locked", int'(locked), 0);
    check("rst_err", int'(err), 0);
    check("rst_err_count", int'(err_count), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Lock from reset on 8,4,2,1,E then 7
    g = 8;
    for (int i = 0; i < 4; i++) good();
    check("lock_early", int'(locked), 0);
    good();
    check("lock_after_E", int'(locked), 1);
    good();

    // Single injected error while locked
    cycle(1, 5, 0);
    g = nxt(g);
    check("single_err_pulse", int'(err), 1);
    check("single_err_count", int'(err_count), 1);
    for (int i = 0; i < 4; i++) good();
    check("flywheel_hold", int'(locked), 1);

    // Lock loss after three consecutive misses, then relock
    bad(); bad();
    check("loss_held", int'(locked), 1);
    bad();
    check("loss_drop", int'(locked), 0);
    for (int i = 0; i < 5; i++) good();
    check("relock", int'(locked), 1);

    // Gaps and zero words while searching
    cycle(0, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0);
    bad(); bad(); bad();
    check("gap_unlocked", int'(locked), 0);
    cycle(1, 0, 0); cycle(0, 9, 0); cycle(1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      good();
      cycle(0, $urandom, 0);
    end

    // Saturation: 16 isolated errors, clear first
    good(1);
    for (int i = 0; i < 16; i++) begin
      bad(); good();
    end
    check("sat_err_count", int'(err_count), CMAX);
    bad(1);
    check("clear_vs_inc", int'(err_count), 0);
    check("clear_err_pulse", int'(err), 1);
    good();

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      int k;
      k = $urandom_range(0, 19);
      if ($urandom_range(0, 3) == 0) cycle(0, $urandom, ($urandom_range(0, 31) == 0));
      else if (k < 16) good($urandom_range(0, 31) == 0);
      else if (k < 18) bad();
      else begin
        cycle(1, 0, 0);
        g = nxt(g);
      end
    end

    // Async reset mid-LOCKED, between clock edges
    for (int i = 0; i < 6; i++) good();
    bad();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("arst_locked", int'(locked), 0);
    check("arst_err", int'(err), 0);
    check("arst_err_count", int'(err_count), 0);
`ifdef LFSR_CHK_BITERR_EN
    check("arst_bit_err_count", int'(bit_err_count), 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    g = 8;
    for (int i = 0; i < 6; i++) good();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
